// File: rtl/perf_event_monitor.sv
// Per-channel qualified event counters with a cycle counter, an IDLE/RUN/DONE
// controller, sticky overflow flags and a registered channel readout.
module perf_event_monitor #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 64,
    parameter int SATURATE    = 0,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic [NUM_CH-1:0] qual_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              running_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;

    // All-ones either wraps to zero or sticks, depending on SATURATE.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (v == ALL_ONES) begin
            return (SATURATE != 0) ? v : '0;
        end
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        if (clear_i) begin
            state_d = IDLE;
            cycle_d = '0;
            ovf_d   = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_d[k] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) state_d = RUN;
                end
                RUN: begin
                    if (!start_i) begin
                        state_d = IDLE;
                    end else begin
                        cycle_d = bump(cycle_q);
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (event_i[k] && qual_i[k]) begin
                                if (cnt_q[k] == ALL_ONES) ovf_d[k] = 1'b1;
                                cnt_d[k] = bump(cnt_q[k]);
                            end
                        end
                        // The edge that reaches the limit still counts its events.
                        if (CYCLE_LIMIT != 0 && 32'(cycle_d) == 32'(CYCLE_LIMIT)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Readout shows the post-update value; out-of-range selects read zero.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_i == SEL_W'(k)) count_d = cnt_d[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cycle_q <= '0;
            count_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign count_o   = count_q;
    assign cycle_o   = cycle_q;
    assign ovf_o     = ovf_q;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench: default-config instance plus 8-bit wrap and saturate instances.
module tb_perf_event_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default configuration instance
  logic        start0 = 0, clear0 = 0;
  logic [1:0]  ev0 = 0, qual0 = 0;
  logic        sel0 = 0;
  logic [31:0] count0, cycle0;
  logic [1:0]  ovf0;
  logic        run0, done0;

  perf_event_monitor u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .clear_i(clear0),
    .event_i(ev0), .qual_i(qual0), .sel_i(sel0),
    .count_o(count0), .cycle_o(cycle0), .ovf_o(ovf0),
    .running_o(run0), .done_o(done0)
  );

  // 8-bit, unlimited, three channels: wrap and saturate variants share inputs
  logic       w_start = 0, w_clear = 0;
  logic [2:0] w_ev = 0, w_qual = 0;
  logic [1:0] w_sel = 0;
  logic [7:0] cw, yw, cs, ys;
  logic [2:0] ow, os;
  logic       rw, dw, rs, ds;

  perf_event_monitor #(.NUM_CH(3), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(w_start), .clear_i(w_clear),
    .event_i(w_ev), .qual_i(w_qual), .sel_i(w_sel),
    .count_o(cw), .cycle_o(yw), .ovf_o(ow), .running_o(rw), .done_o(dw)
  );

  perf_event_monitor #(.NUM_CH(3), .CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(w_start), .clear_i(w_clear),
    .event_i(w_ev), .qual_i(w_qual), .sel_i(w_sel),
    .count_o(cs), .cycle_o(ys), .ovf_o(os), .running_o(rs), .done_o(ds)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        clear;
    logic [1:0]  ev;
    logic [1:0]  qual;
    logic        sel;
    logic [31:0] exp_count;
    logic [31:0] exp_cycle;
    logic [1:0]  exp_ovf;
    logic        exp_run;
    logic        exp_done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic c, input logic [1:0] e,
                              input logic [1:0] q, input logic sl, input int cnt,
                              input int cyc, input logic r);
    vec_t v;
    v.start = s; v.clear = c; v.ev = e; v.qual = q; v.sel = sl;
    v.exp_count = cnt; v.exp_cycle = cyc; v.exp_ovf = 2'b00;
    v.exp_run = r; v.exp_done = 1'b0;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    //          start clr ev     qual   sel cnt cyc run
    vecs[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 2'b11, 2'b11, 0, 1, 1, 1);
    vecs[2]  = mk(1, 0, 2'b01, 2'b11, 0, 2, 2, 1);
    vecs[3]  = mk(1, 0, 2'b11, 2'b01, 0, 3, 3, 1);
    vecs[4]  = mk(1, 0, 2'b11, 2'b11, 1, 2, 4, 1);
    vecs[5]  = mk(0, 0, 2'b11, 2'b11, 0, 4, 4, 0);
    vecs[6]  = mk(0, 0, 2'b11, 2'b11, 1, 2, 4, 0);
    vecs[7]  = mk(1, 0, 2'b00, 2'b00, 0, 4, 4, 1);
    vecs[8]  = mk(1, 0, 2'b01, 2'b11, 0, 5, 5, 1);
    vecs[9]  = mk(1, 0, 2'b01, 2'b11, 0, 6, 6, 1);
    vecs[10] = mk(1, 0, 2'b11, 2'b11, 0, 7, 7, 1);
    vecs[11] = mk(0, 0, 2'b11, 2'b11, 1, 3, 7, 0);
    vecs[12] = mk(0, 0, 2'b00, 2'b00, 0, 7, 7, 0);
    vecs[13] = mk(1, 0, 2'b00, 2'b00, 0, 7, 7, 1);
    vecs[14] = mk(1, 1, 2'b11, 2'b11, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 2'b11, 2'b11, 0, 0, 0, 1);
    vecs[16] = mk(1, 0, 2'b11, 2'b11, 0, 1, 1, 1);

    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count0, 0);
    chk("rst_cycle", cycle0, 0);
    chk("rst_ovf", {30'd0, ovf0}, 0);
    chk("rst_running", {31'd0, run0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_wrap_cycle", {24'd0, yw}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // run to the cycle limit with ch1 disqualified
    start0 = 1; ev0 = 2'b11; qual0 = 2'b01; sel0 = 0;
    tick(64);
    chk("lim_pre_cycle", cycle0, 63);
    chk("lim_pre_done", {31'd0, done0}, 0);
    chk("lim_pre_running", {31'd0, run0}, 1);
    tick(1);
    chk("lim_cycle", cycle0, 64);
    chk("lim_ch0", count0, 64);
    chk("lim_done", {31'd0, done0}, 1);
    chk("lim_running", {31'd0, run0}, 0);
    sel0 = 1;
    tick(1);
    chk("lim_ch1", count0, 0);
    tick(3);
    chk("done_hold_cycle", cycle0, 64);
    chk("done_hold_done", {31'd0, done0}, 1);
    clear0 = 1;
    tick(1);
    chk("clr_done_cycle", cycle0, 0);
    chk("clr_done_count", count0, 0);
    chk("clr_done_done", {31'd0, done0}, 0);
    chk("clr_done_running", {31'd0, run0}, 0);
    clear0 = 0; start0 = 0;

    // pause and resume
    start0 = 1; ev0 = 2'b01; qual0 = 2'b01; sel0 = 0;
    tick(10);
    chk("pause_pre_cycle", cycle0, 9);
    chk("pause_pre_ch0", count0, 9);
    start0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("pause_cycle", cycle0, 9);
      chk("pause_running", {31'd0, run0}, 0);
    end
    start0 = 1;
    tick(1);
    chk("resume_running", {31'd0, run0}, 1);
    chk("resume_cycle", cycle0, 9);
    tick(54);
    chk("resume_pre_cycle", cycle0, 63);
    chk("resume_pre_done", {31'd0, done0}, 0);
    tick(1);
    chk("resume_cycle_end", cycle0, 64);
    chk("resume_ch0_end", count0, 64);
    chk("resume_done", {31'd0, done0}, 1);
    clear0 = 1; start0 = 0;
    tick(1);
    clear0 = 0;

    // table: qualification, readout select, pause, clear-over-start
    for (int i = 0; i < 17; i++) begin
      start0 = vecs[i].start; clear0 = vecs[i].clear;
      ev0 = vecs[i].ev; qual0 = vecs[i].qual; sel0 = vecs[i].sel;
      tick(1);
      chk($sformatf("vec%0d_count", i), count0, vecs[i].exp_count);
      chk($sformatf("vec%0d_cycle", i), cycle0, vecs[i].exp_cycle);
      chk($sformatf("vec%0d_ovf", i), {30'd0, ovf0}, {30'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d_running", i), {31'd0, run0}, {31'd0, vecs[i].exp_run});
      chk($sformatf("vec%0d_done", i), {31'd0, done0}, {31'd0, vecs[i].exp_done});
    end

    // asynchronous reset between edges with cycle_o at 20
    clear0 = 0; start0 = 1; ev0 = 2'b00; qual0 = 2'b00; sel0 = 0;
    tick(19);
    chk("arst_pre_cycle", cycle0, 20);
    #3 rst = 1'b1;
    #1;
    chk("arst_cycle", cycle0, 0);
    chk("arst_count", count0, 0);
    chk("arst_running", {31'd0, run0}, 0);
    chk("arst_done", {31'd0, done0}, 0);
    #1 rst = 1'b0;
    start0 = 0;
    tick(1);
    chk("arst_idle_running", {31'd0, run0}, 0);
    start0 = 1;
    tick(1);
    chk("arst_restart_running", {31'd0, run0}, 1);
    chk("arst_restart_cycle", cycle0, 0);
    tick(1);
    chk("arst_count_cycle", cycle0, 1);

    // 8-bit wrap vs saturate on ch0
    w_start = 1; w_ev = 3'b001; w_qual = 3'b001; w_sel = 0;
    tick(1);
    tick(255);
    chk("w255_count", {24'd0, cw}, 255);
    chk("s255_count", {24'd0, cs}, 255);
    chk("w255_ovf", {29'd0, ow}, 0);
    chk("s255_ovf", {29'd0, os}, 0);
    tick(1);
    chk("w256_count", {24'd0, cw}, 0);
    chk("w256_ovf", {29'd0, ow}, 3'b001);
    chk("s256_count", {24'd0, cs}, 255);
    chk("s256_ovf", {29'd0, os}, 3'b001);
    chk("w256_cycle", {24'd0, yw}, 0);
    chk("s256_cycle", {24'd0, ys}, 255);
    tick(1);
    chk("w257_count", {24'd0, cw}, 1);
    chk("s257_count", {24'd0, cs}, 255);
    chk("w257_cycle", {24'd0, yw}, 1);
    chk("s257_cycle", {24'd0, ys}, 255);
    chk("w257_running", {31'd0, rw}, 1);
    chk("w257_done", {31'd0, dw}, 0);
    w_ev = 3'b000; w_sel = 2'd3;
    tick(1);
    chk("wsel_oor_count", {24'd0, cw}, 0);
    chk("ssel_oor_count", {24'd0, cs}, 0);
    chk("w_ovf_sticky", {29'd0, ow}, 3'b001);
    chk("s_ovf_sticky", {29'd0, os}, 3'b001);
    chk("w258_cycle", {24'd0, yw}, 2);
    w_clear = 1;
    tick(1);
    chk("wclr_ovf", {29'd0, ow}, 0);
    chk("sclr_ovf", {29'd0, os}, 0);
    chk("wclr_cycle", {24'd0, yw}, 0);
    chk("sclr_running", {31'd0, rs}, 0);
    w_clear = 0; w_start = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
